usb_rx: RTL and testbench

Byte-stream packet receiver for the collect board's USB command link, the receive-side counterpart of the packet transmitter. It takes bytes from the link PHY/UART deserializer with a per-byte valid strobe. It hunts for SYNC, then parses PID, length and payload, and checks the payload CRC5. It presents the decoded packet type and command word (`btype`, `data_cmd`) to the command controller with a one-cycle done strobe, or an error strobe with a cause code.

---
 rtl/usb_pkg.sv | 48 ++++
 rtl/crc5_acc.sv | 22 ++
 rtl/usb_rx.sv | 140 ++++++++++++++
 tb/tb_usb_rx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared codes, PID values and CRC5 helper for the USB command link
package usb_pkg;

    localparam logic [3:0] BAG_INIT   = 4'd0;
    localparam logic [3:0] BAG_ACK    = 4'd1;
    localparam logic [3:0] BAG_NAK    = 4'd2;
    localparam logic [3:0] BAG_STL    = 4'd3;
    localparam logic [3:0] BAG_DIDX   = 4'd5;
    localparam logic [3:0] BAG_DPARAM = 4'd6;
    localparam logic [3:0] BAG_DDIDX  = 4'd7;

    localparam logic [7:0] PID_SYNC  = 8'h01;
    localparam logic [7:0] PID_ACK   = 8'h2D;
    localparam logic [7:0] PID_NAK   = 8'hA5;
    localparam logic [7:0] PID_STALL = 8'hE1;
    localparam logic [7:0] PID_CMD   = 8'h1E;

    localparam logic [3:0] HEAD_DIDX   = 4'h9;
    localparam logic [3:0] HEAD_DDIDX  = 4'h1;
    localparam logic [3:0] HEAD_DPARAM = 4'h5;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_PID     = 3'd1;
    localparam logic [2:0] ERR_LEN     = 3'd2;
    localparam logic [2:0] ERR_HEAD    = 3'd3;
    localparam logic [2:0] ERR_CRC     = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT = 3'd5;

    localparam logic [4:0] CRC5_POLY = 5'b00101;
    localparam logic [4:0] CRC5_INIT = 5'h1F;

    typedef enum logic [3:0] {
        S_IDLE, S_WSYNC, S_RPID, S_RLEN0, S_RLEN1, S_RDATA, S_RCRC, S_DONE, S_ERR
    } rx_state_t;

    // One byte through the CRC5 shift register, LSB first.
    function automatic logic [4:0] crc5_byte(input logic [4:0] c_in, input logic [7:0] b);
        logic [4:0] c;
        logic       fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[4] ^ b[i];
            c  = {c[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc5_acc.sv
// rtl/crc5_acc.sv - byte-wide CRC5 accumulator with registered running value
module crc5_acc
    import usb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [4:0] crc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            crc <= CRC5_INIT;
        else if (clr)
            crc <= CRC5_INIT;
        else if (en)
            crc <= crc5_byte(crc, din);
    end

endmodule

// File: rtl/usb_rx.sv
// rtl/usb_rx.sv - SYNC hunt, PID/length/payload parse and CRC5 check for received command packets
module usb_rx
    import usb_pkg::*;
#(
    parameter int TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rxd,
    input  logic        rxd_vld,
    output logic [3:0]  btype,
    output logic [31:0] data_cmd,
    output logic        fd,
    output logic        ferr,
    output logic [2:0]  err_code
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

    rx_state_t     state, state_n;
    logic [TW-1:0] idle_cnt;
    logic [1:0]    num, dlen;
    logic [7:0]    pay0, pay1;
    logic [4:0]    crc;
    logic          crc_clr, crc_en, in_win;
    logic          ld_done, ld_err;
    logic [2:0]    code_n;
    logic [3:0]    btype_n;
    logic [31:0]   cmd_n;

    crc5_acc u_crc (
        .clk (clk),
        .rst (rst),
        .clr (crc_clr),
        .en  (crc_en),
        .din (rxd),
        .crc (crc)
    );

    assign in_win = state inside {S_RPID, S_RLEN0, S_RLEN1, S_RDATA, S_RCRC};

    always_comb begin
        state_n = state;
        ld_done = 1'b0;
        ld_err  = 1'b0;
        code_n  = ERR_NONE;
        btype_n = btype;
        cmd_n   = data_cmd;
        crc_en  = 1'b0;
        crc_clr = (state == S_RPID);
        case (state)
            S_IDLE:  state_n = S_WSYNC;
            S_WSYNC: if (rxd_vld && rxd == PID_SYNC) state_n = S_RPID;
            S_RPID: if (rxd_vld) begin
                case (rxd)
                    PID_ACK:   begin state_n = S_DONE; ld_done = 1'b1; btype_n = BAG_ACK; cmd_n = '0; end
                    PID_NAK:   begin state_n = S_DONE; ld_done = 1'b1; btype_n = BAG_NAK; cmd_n = '0; end
                    PID_STALL: begin state_n = S_DONE; ld_done = 1'b1; btype_n = BAG_STL; cmd_n = '0; end
                    PID_CMD:   state_n = S_RLEN0;
                    default:   begin state_n = S_ERR; ld_err = 1'b1; code_n = ERR_PID; end
                endcase
            end
            S_RLEN0: if (rxd_vld) begin
                if (rxd == 8'h00) state_n = S_RLEN1;
                else begin state_n = S_ERR; ld_err = 1'b1; code_n = ERR_LEN; end
            end
            S_RLEN1: if (rxd_vld) begin
                if (rxd == 8'd1 || rxd == 8'd2) state_n = S_RDATA;
                else begin state_n = S_ERR; ld_err = 1'b1; code_n = ERR_LEN; end
            end
            S_RDATA: if (rxd_vld) begin
                crc_en = 1'b1;
                if (num == dlen - 2'd1) state_n = S_RCRC;
            end
            S_RCRC: if (rxd_vld) begin
                // CRC is judged before the head nibble so a corrupted frame reports CRC
                if (rxd != {3'b000, ~crc}) begin
                    state_n = S_ERR; ld_err = 1'b1; code_n = ERR_CRC;
                end else if (dlen == 2'd1 && pay0[7:4] == HEAD_DIDX) begin
                    state_n = S_DONE; ld_done = 1'b1; btype_n = BAG_DIDX;
                    cmd_n = {pay0[3:0], 28'h0};
                end else if (dlen == 2'd1 && pay0[7:4] == HEAD_DDIDX) begin
                    state_n = S_DONE; ld_done = 1'b1; btype_n = BAG_DDIDX;
                    cmd_n = {4'h0, pay0[3:0], 24'h0};
                end else if (dlen == 2'd2 && pay0[7:4] == HEAD_DPARAM) begin
                    state_n = S_DONE; ld_done = 1'b1; btype_n = BAG_DPARAM;
                    cmd_n = {8'h0, pay0[3:0], pay1, 12'h0};
                end else begin
                    state_n = S_ERR; ld_err = 1'b1; code_n = ERR_HEAD;
                end
            end
            // A byte landing in DONE/ERR already belongs to the next frame's hunt
            S_DONE, S_ERR: state_n = (rxd_vld && rxd == PID_SYNC) ? S_RPID : S_WSYNC;
            default: state_n = S_IDLE;
        endcase
        if (in_win && !rxd_vld && idle_cnt == IDLE_LAST) begin
            state_n = S_ERR; ld_err = 1'b1; code_n = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            idle_cnt <= '0;
            num      <= '0;
            dlen     <= '0;
            pay0     <= '0;
            pay1     <= '0;
            fd       <= 1'b0;
            ferr     <= 1'b0;
            err_code <= '0;
            btype    <= '0;
            data_cmd <= '0;
        end else begin
            state    <= state_n;
            fd       <= ld_done;
            ferr     <= ld_err;
            idle_cnt <= (in_win && !rxd_vld) ? idle_cnt + 1'b1 : '0;
            if (state == S_RLEN1 && rxd_vld)
                dlen <= rxd[1:0];
            if (state == S_RDATA) begin
                if (rxd_vld) begin
                    if (num == 2'd0) pay0 <= rxd;
                    else             pay1 <= rxd;
                    num <= num + 2'd1;
                end
            end else begin
                num <= '0;
            end
            if (ld_done) begin
                btype    <= btype_n;
                data_cmd <= cmd_n;
            end
            if (ld_err)
                err_code <= code_n;
        end
    end

endmodule

// File: tb/tb_usb_rx.sv
// tb/tb_usb_rx.sv - scoreboard bench for usb_rx with a frame-level reference model
module tb_usb_rx;

    localparam int TO = 16;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic        is_err;
        logic [3:0]  btype;
        logic [31:0] cmd;
        logic [2:0]  code;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rxd = 8'h00;
    logic        rxd_vld = 1'b0;
    logic [3:0]  btype;
    logic [31:0] data_cmd;
    logic        fd, ferr;
    logic [2:0]  err_code;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    logic [3:0]  m_btype = 4'd0;
    logic [31:0] m_cmd = 32'd0;
    logic [2:0]  m_code = 3'd0;

    usb_rx #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .rxd_vld  (rxd_vld),
        .btype    (btype),
        .data_cmd (data_cmd),
        .fd       (fd),
        .ferr     (ferr),
        .err_code (err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] crc_of(input bq_t p);
        int c = 31;
        int fb;
        foreach (p[k])
            for (int i = 0; i < 8; i++) begin
                fb = ((c >> 4) & 1) ^ ((p[k] >> i) & 1);
                c  = ((c << 1) & 31) ^ (fb != 0 ? 5 : 0);
            end
        return 8'((~c) & 31);
    endfunction

    // Walks a whole frame the way the link protocol defines it and predicts the outcome.
    function automatic void model(input bq_t fr, output exp_t e);
        int i = 0;
        logic [7:0] pid, l0, l1, crcb;
        bq_t p;
        logic good = 1'b0;
        logic [3:0] bt = 4'd0;
        logic [31:0] cmd = 32'd0;
        logic [2:0] code = 3'd0;
        while (fr[i] != 8'h01) i++;
        i++;
        pid = fr[i]; i++;
        if (pid == 8'h2D)      begin good = 1; bt = 4'd1; end
        else if (pid == 8'hA5) begin good = 1; bt = 4'd2; end
        else if (pid == 8'hE1) begin good = 1; bt = 4'd3; end
        else if (pid != 8'h1E) code = 3'd1;
        else begin
            l0 = fr[i]; i++;
            l1 = fr[i]; i++;
            if (l0 != 8'h00 || !(l1 == 8'd1 || l1 == 8'd2)) code = 3'd2;
            else begin
                for (int k = 0; k < int'(l1); k++) begin p.push_back(fr[i]); i++; end
                crcb = fr[i];
                if (crcb != crc_of(p)) code = 3'd4;
                else if (l1 == 8'd1 && p[0][7:4] == 4'h9) begin
                    good = 1; bt = 4'd5; cmd = 32'(p[0][3:0]) << 28;
                end else if (l1 == 8'd1 && p[0][7:4] == 4'h1) begin
                    good = 1; bt = 4'd7; cmd = 32'(p[0][3:0]) << 24;
                end else if (l1 == 8'd2 && p[0][7:4] == 4'h5) begin
                    good = 1; bt = 4'd6;
                    cmd = (32'(p[0][3:0]) << 20) | (32'(p[1][7:4]) << 16) | (32'(p[1][3:0]) << 12);
                end else code = 3'd3;
            end
        end
        if (good) begin m_btype = bt; m_cmd = cmd; end
        else m_code = code;
        e.is_err = !good;
        e.btype  = m_btype;
        e.cmd    = m_cmd;
        e.code   = m_code;
        e.cyc    = 0;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b, output int acc);
        rxd = b;
        rxd_vld = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        rxd_vld = 1'b0;
    endtask

    task automatic send_frame(input bq_t fr, input int gapmax);
        exp_t e;
        int acc;
        model(fr, e);
        for (int i = 0; i < fr.size(); i++) begin
            send(fr[i], acc);
            if (i == fr.size() - 1) begin e.cyc = acc; sb.push_back(e); end
            else if (gapmax > 0) idle($urandom_range(0, gapmax));
        end
    endtask

    function automatic bq_t cmd_frame(input bq_t p, input logic [7:0] flip);
        bq_t fr = '{8'h01, 8'h1E, 8'h00};
        fr.push_back(8'(p.size()));
        foreach (p[k]) fr.push_back(p[k]);
        fr.push_back(crc_of(p) ^ flip);
        return fr;
    endfunction

    function automatic bq_t gen_frame();
        bq_t fr, p;
        logic [7:0] b;
        int kind = $urandom_range(0, 8);
        repeat ($urandom_range(0, 2)) fr.push_back(8'($urandom_range(2, 255)));
        case (kind)
            0: begin
                fr.push_back(8'h01);
                case ($urandom_range(0, 2))
                    0: fr.push_back(8'h2D);
                    1: fr.push_back(8'hA5);
                    default: fr.push_back(8'hE1);
                endcase
            end
            4: begin
                do b = 8'($urandom); while (b == 8'h2D || b == 8'hA5 || b == 8'hE1 || b == 8'h1E);
                fr.push_back(8'h01); fr.push_back(b);
            end
            5: begin
                fr.push_back(8'h01); fr.push_back(8'h1E); fr.push_back(8'($urandom_range(1, 255)));
            end
            6: begin
                fr.push_back(8'h01); fr.push_back(8'h1E); fr.push_back(8'h00);
                fr.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(3, 255)));
            end
            default: begin
                case (kind)
                    1: p.push_back({4'h9, 4'($urandom)});
                    2: p.push_back({4'h1, 4'($urandom)});
                    7: begin
                        p.push_back(8'($urandom));
                        if ($urandom_range(0, 1) == 0) begin
                            while (p[0][7:4] == 4'h9 || p[0][7:4] == 4'h1) p[0] = 8'($urandom);
                        end else begin
                            while (p[0][7:4] == 4'h5) p[0] = 8'($urandom);
                            p.push_back(8'($urandom));
                        end
                    end
                    default: begin p.push_back({4'h5, 4'($urandom)}); p.push_back(8'($urandom)); end
                endcase
                foreach (fr[k]) p.insert(k, 8'h00);
                for (int k = 0; k < fr.size(); k++) void'(p.pop_front());
                fr = {fr, cmd_frame(p, (kind == 8) ? 8'(1 << $urandom_range(0, 7)) : 8'h00)};
            end
        endcase
        return fr;
    endfunction

    always @(negedge clk) begin
        if (!rst && (fd || ferr)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe actual fd=%0b ferr=%0b expected none (cycle %0d)", fd, ferr, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("ferr", 32'(ferr), 32'(mon_e.is_err));
                chk("fd", 32'(fd), 32'(!mon_e.is_err));
                chk("btype", 32'(btype), 32'(mon_e.btype));
                chk("data_cmd", data_cmd, mon_e.cmd);
                chk("err_code", 32'(err_code), 32'(mon_e.code));
                chk("strobe_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int acc;
        bq_t p;
        idle(3);
        chk("reset_btype", 32'(btype), 32'd0);
        chk("reset_cmd", data_cmd, 32'd0);
        chk("reset_strobes", 32'({fd, ferr}), 32'd0);
        chk("reset_code", 32'(err_code), 32'd0);
        rst = 1'b0;
        idle(3);

        send_frame('{8'h01, 8'h2D}, 0);
        send_frame({8'h55, 8'hAA, cmd_frame('{8'h93}, 8'h00)}, 0);
        idle(2);
        send_frame(cmd_frame('{8'h57, 8'hAB}, 8'h00), 0);
        send_frame(cmd_frame('{8'h57, 8'hAB}, 8'h01), 0);
        send_frame('{8'h01, 8'h77}, 0);
        send_frame('{8'h01, 8'h1E, 8'h00, 8'h03}, 0);
        send_frame('{8'h01, 8'hA5}, 0);
        idle(2);

        send(8'h01, acc); send(8'h1E, acc); send(8'h00, acc);
        m_code = 3'd5;
        e.is_err = 1'b1; e.btype = m_btype; e.cmd = m_cmd; e.code = m_code; e.cyc = acc + TO;
        sb.push_back(e);
        idle(TO + 4);
        send_frame('{8'h01, 8'hE1}, 0);
        idle(2);

        send(8'h01, acc); send(8'h1E, acc); send(8'h00, acc); send(8'h01, acc);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        m_btype = 4'd0; m_cmd = 32'd0; m_code = 3'd0;
        chk("midrst_btype", 32'(btype), 32'd0);
        chk("midrst_cmd", data_cmd, 32'd0);
        chk("midrst_code", 32'(err_code), 32'd0);
        idle(2);
        send_frame(cmd_frame('{8'h14}, 8'h00), 0);
        idle(3);

        for (int n = 0; n < 60; n++) begin
            p = gen_frame();
            send_frame(p, $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
        end
        idle(TO + 8);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
